tennis_ball_ctrl: RTL and testbench

Game-play engine for the LED tennis game. It sits directly downstream of the ball-speed clock divider and consumes that divider's slow `divided_clk` as a step tick. On each tick it advances a one-hot ball across the LED row and resolves returns and misses from the two debounced player buttons. It also keeps score and drives the LED row and score outputs to the display logic.

---
 rtl/tennis_ball_ctrl_if.sv | 25 ++
 rtl/tennis_ball_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tennis_ball_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tennis_ball_ctrl_if.sv
// Connection bundle between the tennis game engine and its neighbours:
// ball-speed tick and player buttons in; LED row, scores and point events out.
interface tennis_ball_ctrl_if #(
    parameter int N_LEDS = 16
);
    logic              ball_clk;
    logic              hit_l;
    logic              hit_r;
    logic [N_LEDS-1:0] led;
    logic [3:0]        score_l;
    logic [3:0]        score_r;
    logic              point_l;
    logic              point_r;
    logic              game_over;

    modport master (
        output ball_clk, hit_l, hit_r,
        input  led, score_l, score_r, point_l, point_r, game_over
    );

    modport slave (
        input  ball_clk, hit_l, hit_r,
        output led, score_l, score_r, point_l, point_r, game_over
    );
endinterface

// File: rtl/tennis_ball_ctrl.sv
// LED tennis game engine: steps a one-hot ball on each ball_clk rise, resolves
// returns and misses from the player buttons, keeps score and drives the LEDs.
module tennis_ball_ctrl #(
    parameter int N_LEDS      = 16,
    parameter int WIN_SCORE   = 7,
    parameter int POINT_TICKS = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    tennis_ball_ctrl_if.slave  bus
);
    localparam int              PW         = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int              TW         = (POINT_TICKS > 1) ? $clog2(POINT_TICKS + 1) : 1;
    localparam logic [PW-1:0]   POS_MAX    = PW'(N_LEDS - 1);
    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);
    localparam logic [TW-1:0]   TICKS_DONE = TW'(POINT_TICKS);

    typedef enum logic [2:0] {
        SERVE,
        MOVE_R,
        MOVE_L,
        POINT,
        GAME_OVER
    } state_t;

    state_t            state_reg;
    logic [PW-1:0]     pos_reg;
    logic              server_reg;
    logic [TW-1:0]     tick_cnt_reg;
    logic              ball_sync1_reg;
    logic              ball_sync2_reg;
    logic              ball_prev_reg;
    logic              hit_l_q_reg;
    logic              hit_l_prev_reg;
    logic              hit_r_q_reg;
    logic              hit_r_prev_reg;
    logic [N_LEDS-1:0] led_reg;
    logic [3:0]        score_l_reg;
    logic [3:0]        score_r_reg;
    logic              point_l_reg;
    logic              point_r_reg;
    logic              game_over_reg;

    logic              step;
    logic              hit_l_ev;
    logic              hit_r_ev;
    logic [N_LEDS-1:0] onehot;
    logic [N_LEDS-1:0] upper_half;
    logic [N_LEDS-1:0] lower_half;
    logic [N_LEDS-1:0] led_pattern;

    assign step     = ball_sync2_reg & ~ball_prev_reg;
    assign hit_l_ev = hit_l_q_reg & ~hit_l_prev_reg;
    assign hit_r_ev = hit_r_q_reg & ~hit_r_prev_reg;

    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led_lane
            assign onehot[gi]     = (pos_reg == PW'(gi));
            assign upper_half[gi] = (gi >= N_LEDS / 2);
            assign lower_half[gi] = (gi < N_LEDS / 2);
        end
    endgenerate

    // The LED row is a registered image of the current state, so it trails
    // pos/state by one clock.
    always_comb begin
        led_pattern = onehot;
        case (state_reg)
            POINT:     led_pattern = tick_cnt_reg[0] ? '0 : '1;
            GAME_OVER: led_pattern = (score_l_reg == WIN) ? upper_half : lower_half;
            default:   led_pattern = onehot;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SERVE;
            pos_reg        <= '0;
            server_reg     <= 1'b0;
            tick_cnt_reg   <= '0;
            ball_sync1_reg <= 1'b0;
            ball_sync2_reg <= 1'b0;
            ball_prev_reg  <= 1'b0;
            hit_l_q_reg    <= 1'b0;
            hit_l_prev_reg <= 1'b0;
            hit_r_q_reg    <= 1'b0;
            hit_r_prev_reg <= 1'b0;
            led_reg        <= N_LEDS'(1);
            score_l_reg    <= '0;
            score_r_reg    <= '0;
            point_l_reg    <= 1'b0;
            point_r_reg    <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            ball_sync1_reg <= bus.ball_clk;
            ball_sync2_reg <= ball_sync1_reg;
            ball_prev_reg  <= ball_sync2_reg;
            hit_l_q_reg    <= bus.hit_l;
            hit_l_prev_reg <= hit_l_q_reg;
            hit_r_q_reg    <= bus.hit_r;
            hit_r_prev_reg <= hit_r_q_reg;
            led_reg        <= led_pattern;
            point_l_reg    <= 1'b0;
            point_r_reg    <= 1'b0;

            case (state_reg)
                SERVE: begin
                    if (!server_reg && hit_l_ev) begin
                        state_reg <= MOVE_R;
                    end else if (server_reg && hit_r_ev) begin
                        state_reg <= MOVE_L;
                    end
                end
                MOVE_R: begin
                    // A return at the end beats a coincident step.
                    if (hit_r_ev && pos_reg == POS_MAX) begin
                        state_reg <= MOVE_L;
                    end else if (step) begin
                        if (pos_reg == POS_MAX) begin
                            point_l_reg  <= 1'b1;
                            server_reg   <= 1'b1;
                            tick_cnt_reg <= '0;
                            if (score_l_reg != WIN) begin
                                score_l_reg <= score_l_reg + 4'd1;
                            end
                            if (score_l_reg + 4'd1 >= WIN) begin
                                state_reg     <= GAME_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= POINT;
                            end
                        end else begin
                            pos_reg <= pos_reg + PW'(1);
                        end
                    end
                end
                MOVE_L: begin
                    if (hit_l_ev && pos_reg == '0) begin
                        state_reg <= MOVE_R;
                    end else if (step) begin
                        if (pos_reg == '0) begin
                            point_r_reg  <= 1'b1;
                            server_reg   <= 1'b0;
                            tick_cnt_reg <= '0;
                            if (score_r_reg != WIN) begin
                                score_r_reg <= score_r_reg + 4'd1;
                            end
                            if (score_r_reg + 4'd1 >= WIN) begin
                                state_reg     <= GAME_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= POINT;
                            end
                        end else begin
                            pos_reg <= pos_reg - PW'(1);
                        end
                    end
                end
                POINT: begin
                    if (step) begin
                        if (tick_cnt_reg + TW'(1) == TICKS_DONE) begin
                            state_reg    <= SERVE;
                            tick_cnt_reg <= '0;
                            pos_reg      <= server_reg ? POS_MAX : '0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    state_reg <= GAME_OVER;
                end
                default: begin
                    state_reg <= SERVE;
                end
            endcase
        end
    end

    assign bus.led       = led_reg;
    assign bus.score_l   = score_l_reg;
    assign bus.score_r   = score_r_reg;
    assign bus.point_l   = point_l_reg;
    assign bus.point_r   = point_r_reg;
    assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_tennis_ball_ctrl.sv
// Directed bench for tennis_ball_ctrl: serve, walk, returns, tie-break, miss,
// blink, game end and asynchronous reset mid-rally, with hand-computed LED values.
module tb_tennis_ball_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tennis_ball_ctrl_if #(.N_LEDS(16)) bus ();

    tennis_ball_ctrl #(
        .N_LEDS(16),
        .WIN_SCORE(7),
        .POINT_TICKS(2)
    ) dut (
        .clk_in(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic hit_pulse(input bit right);
        if (right) bus.hit_r = 1'b1; else bus.hit_l = 1'b1;
        wait_neg(2);
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;
        wait_neg(2);
    endtask

    // One ball_clk period; the new LED image is visible at the end.
    task automatic do_step(input logic [15:0] exp_led, input string tag);
        bus.ball_clk = 1'b1;
        wait_neg(2);
        bus.ball_clk = 1'b0;
        wait_neg(2);
        chk(tag, bus.led, exp_led);
        $display("step %s led=%04h", tag, bus.led);
    endtask

    // Step on which the ball leaves the row: check the one-cycle point pulse.
    task automatic miss_step(input bit exp_pl, input bit exp_pr, input int exp_sl,
                             input int exp_sr, input bit exp_go);
        bus.ball_clk = 1'b1;
        wait_neg(2);
        bus.ball_clk = 1'b0;
        wait_neg(1);
        chk("point_l_pulse", bus.point_l, exp_pl);
        chk("point_r_pulse", bus.point_r, exp_pr);
        chk("score_l", bus.score_l, exp_sl);
        chk("score_r", bus.score_r, exp_sr);
        chk("game_over", bus.game_over, exp_go);
        wait_neg(1);
        chk("point_l_low", bus.point_l, 0);
        chk("point_r_low", bus.point_r, 0);
        $display("miss score_l=%0d score_r=%0d game_over=%0b", bus.score_l, bus.score_r, bus.game_over);
    endtask

    task automatic walk_up(input int from_pos, input int to_pos);
        for (int i = from_pos; i <= to_pos; i++) do_step(16'(32'd1 << i), "walk_up");
    endtask

    task automatic walk_down(input int from_pos, input int to_pos);
        for (int i = from_pos; i >= to_pos; i--) do_step(16'(32'd1 << i), "walk_down");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.ball_clk = 1'b0;
        bus.hit_l    = 1'b0;
        bus.hit_r    = 1'b0;

        // Reset state
        wait_neg(3);
        chk("rst_led", bus.led, 16'h0001);
        chk("rst_score_l", bus.score_l, 0);
        chk("rst_score_r", bus.score_r, 0);
        chk("rst_game_over", bus.game_over, 0);
        rst_n = 1'b1;
        wait_neg(2);
        chk("idle_led", bus.led, 16'h0001);

        // Serve from left: no movement until the first step
        hit_pulse(1'b0);
        chk("serve_led", bus.led, 16'h0001);

        // First step with latency check: unchanged two edges after, new after three
        bus.ball_clk = 1'b1;
        wait_neg(2);
        bus.ball_clk = 1'b0;
        wait_neg(1);
        chk("latency_pre", bus.led, 16'h0001);
        wait_neg(1);
        chk("latency_post", bus.led, 16'h0002);

        // Walk right; early hit_r at pos 13 must be ignored
        walk_up(2, 13);
        hit_pulse(1'b1);
        chk("early_hit_led", bus.led, 16'h2000);
        walk_up(14, 15);

        // Tie-break: hit_r edge coincides with the step at pos 15
        bus.ball_clk = 1'b1;
        wait_neg(1);
        bus.hit_r = 1'b1;
        wait_neg(1);
        bus.ball_clk = 1'b0;
        wait_neg(1);
        bus.hit_r = 1'b0;
        wait_neg(1);
        chk("tiebreak_led", bus.led, 16'h8000);
        chk("tiebreak_no_point", bus.score_l, 0);
        walk_down(14, 0);

        // Plain left return at pos 0, then back to the right end
        hit_pulse(1'b0);
        walk_up(1, 15);

        // Right misses: left point, blink, serve from right
        miss_step(1'b1, 1'b0, 1, 0, 1'b0);
        chk("blink_on", bus.led, 16'hFFFF);
        do_step(16'h0000, "blink_off");
        do_step(16'h8000, "serve_right_pos");

        // Wrong server button ignored; right serves, left misses
        hit_pulse(1'b0);
        do_step(16'h8000, "serve_hold");
        hit_pulse(1'b1);
        walk_down(14, 0);
        miss_step(1'b0, 1'b1, 1, 1, 1'b0);
        do_step(16'h0000, "blink_off");
        do_step(16'h0001, "serve_left_pos");

        // Left scores points 2..7
        for (int p = 2; p <= 7; p++) begin
            if (p == 2) begin
                hit_pulse(1'b0);
                walk_up(1, 15);
            end else begin
                hit_pulse(1'b1);
                walk_down(14, 0);
                hit_pulse(1'b0);
                walk_up(1, 15);
            end
            miss_step(1'b1, 1'b0, p, 1, (p == 7));
            if (p < 7) begin
                do_step(16'h0000, "blink_off");
                do_step(16'h8000, "serve_right_pos");
            end
        end
        chk("game_over_led", bus.led, 16'hFF00);

        // Game over holds against ticks and buttons
        do_step(16'hFF00, "go_hold");
        hit_pulse(1'b0);
        hit_pulse(1'b1);
        do_step(16'hFF00, "go_hold");
        chk("go_score_l", bus.score_l, 7);
        chk("go_score_r", bus.score_r, 1);
        chk("go_flag", bus.game_over, 1);

        // Fresh game: right wins three points via a separate-cycle right return
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(2);
        for (int p = 1; p <= 3; p++) begin
            hit_pulse(1'b0);
            walk_up(1, 15);
            hit_pulse(1'b1);
            walk_down(14, 0);
            miss_step(1'b0, 1'b1, 0, p, 1'b0);
            do_step(16'h0000, "blink_off");
            do_step(16'h0001, "serve_left_pos");
        end
        hit_pulse(1'b0);
        walk_up(1, 9);
        chk("pre_reset_led", bus.led, 16'h0200);
        chk("pre_reset_score_r", bus.score_r, 3);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", bus.led, 16'h0001);
        chk("async_rst_score_r", bus.score_r, 0);
        chk("async_rst_score_l", bus.score_l, 0);
        chk("async_rst_point", {bus.point_l, bus.point_r}, 0);
        chk("async_rst_game_over", bus.game_over, 0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
